// File: rtl/fft_radix2_iter.sv
// Iterative radix-2 DIT FFT: bit-reversed load, one in-place butterfly per clock,
// natural-order unload with optional 1/N scaling for the inverse transform.
module fft_radix2_iter #(
    parameter int N_POINTS = 8,
    parameter int DATA_W   = 32,
    parameter int FRAC_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           in_r,
    input  logic [DATA_W-1:0]           in_i,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        inverse,
    output logic [DATA_W-1:0]           out_r,
    output logic [DATA_W-1:0]           out_i,
    output logic [$clog2(N_POINTS)-1:0] out_index,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy
);

    localparam int L    = $clog2(N_POINTS);
    localparam int BW   = L - 1;
    localparam int SW   = $clog2(L);
    localparam int TW_L = (FRAC_W > 16) ? FRAC_W - 16 : 0;
    localparam int TW_R = (FRAC_W < 16) ? 16 - FRAC_W : 0;

    if (N_POINTS != 8 && N_POINTS != 16 && N_POINTS != 32) begin : g_bad_n
        $error("fft_radix2_iter: N_POINTS must be 8, 16 or 32");
    end

    typedef enum logic [1:0] {StIdle, StLoad, StCalc, StUnload} state_e;

    state_e          state;
    logic [L-1:0]    cnt;
    logic [SW-1:0]   stage;
    logic [BW-1:0]   bfly;
    logic            inv_q;

    logic signed [DATA_W-1:0] mem_r [N_POINTS];
    logic signed [DATA_W-1:0] mem_i [N_POINTS];

    logic [L-1:0]               half, jj, addr_a, addr_c;
    logic [3:0]                 tw_m;
    logic signed [DATA_W-1:0]   cos_v, sin_v, w_r, w_i;
    logic signed [DATA_W-1:0]   xa_r, xa_i, xc_r, xc_i, t_r, t_i;
    logic signed [2*DATA_W-1:0] p_rr, p_ii, p_ri, p_ir, sum_r, sum_i;
    logic signed [DATA_W-1:0]   rd_r, rd_i, sh_r, sh_i;

    function automatic logic [L-1:0] bitrev(input logic [L-1:0] v);
        for (int i = 0; i < L; i++) begin
            bitrev[i] = v[L-1-i];
        end
    endfunction

    // Quarter-wave cosine table in Q16, cos(2*pi*m/32) for m = 0..8.
    function automatic logic signed [DATA_W-1:0] cos_q16(input logic [3:0] m);
        case (m)
            4'd0:    return DATA_W'(65536);
            4'd1:    return DATA_W'(64277);
            4'd2:    return DATA_W'(60547);
            4'd3:    return DATA_W'(54491);
            4'd4:    return DATA_W'(46341);
            4'd5:    return DATA_W'(36410);
            4'd6:    return DATA_W'(25080);
            4'd7:    return DATA_W'(12785);
            default: return '0;
        endcase
    endfunction

    always_comb begin
        half   = L'(1) << stage;
        jj     = L'(bfly) & (half - L'(1));
        addr_a = ((L'(bfly) >> stage) << (int'(stage) + 1)) | jj;
        addr_c = addr_a + half;
        tw_m   = 4'(jj) << (4 - int'(stage));

        cos_v = (tw_m <= 4'd8) ? cos_q16(tw_m) : -cos_q16(4'(5'd16 - 5'(tw_m)));
        sin_v = (tw_m <= 4'd8) ? cos_q16(4'd8 - tw_m) : cos_q16(tw_m - 4'd8);
        w_r   = (cos_v <<< TW_L) >>> TW_R;
        w_i   = inv_q ? ((sin_v <<< TW_L) >>> TW_R) : -((sin_v <<< TW_L) >>> TW_R);

        xa_r = mem_r[addr_a];
        xa_i = mem_i[addr_a];
        xc_r = mem_r[addr_c];
        xc_i = mem_i[addr_c];

        p_rr  = (2*DATA_W)'(w_r) * (2*DATA_W)'(xc_r);
        p_ii  = (2*DATA_W)'(w_i) * (2*DATA_W)'(xc_i);
        p_ri  = (2*DATA_W)'(w_r) * (2*DATA_W)'(xc_i);
        p_ir  = (2*DATA_W)'(w_i) * (2*DATA_W)'(xc_r);
        sum_r = p_rr - p_ii;
        sum_i = p_ri + p_ir;
        t_r   = DATA_W'(sum_r >>> FRAC_W);
        t_i   = DATA_W'(sum_i >>> FRAC_W);
    end

    always_ff @(posedge clk) begin
        if (in_valid && (state == StIdle || state == StLoad)) begin
            mem_r[bitrev(cnt)] <= in_r;
            mem_i[bitrev(cnt)] <= in_i;
        end else if (state == StCalc) begin
            mem_r[addr_a] <= xa_r + t_r;
            mem_i[addr_a] <= xa_i + t_i;
            mem_r[addr_c] <= xa_r - t_r;
            mem_i[addr_c] <= xa_i - t_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            cnt       <= '0;
            stage     <= '0;
            bfly      <= '0;
            inv_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_index <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        inv_q <= inverse;
                        cnt   <= L'(1);
                        busy  <= 1'b1;
                        state <= StLoad;
                    end
                end
                StLoad: begin
                    // cnt wraps back to zero on the last sample, ready for the next frame
                    if (in_valid) begin
                        cnt <= cnt + L'(1);
                        if (cnt == L'(N_POINTS - 1)) begin
                            in_ready <= 1'b0;
                            state    <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (bfly == BW'(N_POINTS / 2 - 1)) begin
                        bfly <= '0;
                        if (stage == SW'(L - 1)) begin
                            stage     <= '0;
                            out_valid <= 1'b1;
                            state     <= StUnload;
                        end else begin
                            stage <= stage + SW'(1);
                        end
                    end else begin
                        bfly <= bfly + BW'(1);
                    end
                end
                StUnload: begin
                    if (out_ready) begin
                        if (out_index == L'(N_POINTS - 1)) begin
                            out_index <= '0;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            state     <= StIdle;
                        end else begin
                            out_index <= out_index + L'(1);
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Shift in a signed temporary so the ternary below cannot turn it into a logical shift.
    always_comb begin
        rd_r  = mem_r[out_index];
        rd_i  = mem_i[out_index];
        sh_r  = inv_q ? (rd_r >>> L) : rd_r;
        sh_i  = inv_q ? (rd_i >>> L) : rd_i;
        out_r = out_valid ? sh_r : '0;
        out_i = out_valid ? sh_i : '0;
    end

    assign out_last = out_valid && (out_index == L'(N_POINTS - 1));

endmodule

// File: tb/tb_fft_radix2_iter.sv
// Scoreboard bench for fft_radix2_iter: N = 8, 16 and 32 instances checked against a
// floating-point DFT, plus round trip, backpressure, latency and mid-frame reset.
module tb_fft_radix2_iter;

    localparam real PI = 3.14159265358979;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_r, in_i;
    logic [2:0]  in_valid;
    logic        inverse, out_ready;
    wire  [2:0]  in_ready, out_valid, out_last, busy;
    wire  [31:0] o_r [3];
    wire  [31:0] o_i [3];
    wire  [4:0]  o_idx [3];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NP = 8 << g;
        logic [$clog2(NP)-1:0] idx;
        fft_radix2_iter #(.N_POINTS(NP), .DATA_W(32), .FRAC_W(16)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_r     (in_r),
            .in_i     (in_i),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .inverse  (inverse),
            .out_r    (o_r[g]),
            .out_i    (o_i[g]),
            .out_index(idx),
            .out_valid(out_valid[g]),
            .out_ready(out_ready),
            .out_last (out_last[g]),
            .busy     (busy[g])
        );
        assign o_idx[g] = 5'(idx);
    end

    typedef struct {int idx; int r; int i; int tol;} exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;
    int c0 = 0;
    int smp_r [32], smp_i [32], org_r [32], org_i [32], cap_r [32], cap_i [32];

    task automatic check_val(input string tag, input longint obs, input longint exp,
                             input longint tol);
        n_vec++;
        if (obs > exp + tol || obs < exp - tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (+/-%0d) at t=%0t", tag, obs, exp, tol,
                     $time);
        end
    endtask

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    task automatic push_dft(input int np, input bit inv, input int tol);
        for (int k = 0; k < np; k++) begin
            real re = 0.0, im = 0.0;
            for (int n = 0; n < np; n++) begin
                real a = 2.0 * PI * real'(k * n) / real'(np);
                real c = $cos(a), s = $sin(a);
                if (!inv) begin
                    re += smp_r[n] * c + smp_i[n] * s;
                    im += smp_i[n] * c - smp_r[n] * s;
                end else begin
                    re += smp_r[n] * c - smp_i[n] * s;
                    im += smp_i[n] * c + smp_r[n] * s;
                end
            end
            if (inv) begin
                re = re / real'(np);
                im = im / real'(np);
            end
            sb.push_back('{k, rnd(re), rnd(im), tol});
        end
    endtask

    // inverse flips after the first sample; the DUT must keep the latched mode.
    task automatic send_frame(input int sel, input int np, input bit inv, input bit gaps);
        int n = 0;
        while (n < np) begin
            int w = 0;
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = '0;
                @(posedge clk); #1;
                continue;
            end
            while (!in_ready[sel] && w < 100) begin
                @(posedge clk); #1;
                w++;
            end
            if (w >= 100) check_val("in_ready_wait", longint'(in_ready[sel]), 1, 0);
            in_r     = smp_r[n];
            in_i     = smp_i[n];
            inverse  = (n == 0) ? inv : !inv;
            in_valid = 3'b001 << sel;
            @(posedge clk); #1;
            if (n == 0) c0 = cyc;
            n++;
        end
        in_valid = '0;
    endtask

    task automatic collect(input int sel, input int np, input logic [3:0] pat,
                           input int lat_exp);
        int     got = 0, t = 0;
        bit     seen = 0, stalled = 0;
        longint hold_r = 0, hold_i = 0, hold_idx = 0;
        exp_t   e;
        while (got < np && t < 3000) begin
            out_ready = pat[t % 4];
            @(negedge clk);
            if (out_valid[sel]) begin
                if (!seen && lat_exp > 0) check_val("latency", cyc - c0 + 1, lat_exp, 0);
                seen = 1;
                check_val("in_ready_unload", longint'(in_ready[sel]), 0, 0);
                if (stalled) begin
                    check_val("stall_r", $signed(o_r[sel]), hold_r, 0);
                    check_val("stall_i", $signed(o_i[sel]), hold_i, 0);
                    check_val("stall_idx", o_idx[sel], hold_idx, 0);
                end
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        check_val("sb_underflow", got, np, 0);
                        got = np;
                    end else begin
                        e = sb.pop_front();
                        check_val("index", o_idx[sel], e.idx, 0);
                        check_val("bin_r", $signed(o_r[sel]), e.r, e.tol);
                        check_val("bin_i", $signed(o_i[sel]), e.i, e.tol);
                        check_val("last", longint'(out_last[sel]), (e.idx == np - 1) ? 1 : 0, 0);
                        cap_r[e.idx] = $signed(o_r[sel]);
                        cap_i[e.idx] = $signed(o_i[sel]);
                        got++;
                    end
                    stalled = 0;
                end else begin
                    stalled  = 1;
                    hold_r   = $signed(o_r[sel]);
                    hold_i   = $signed(o_i[sel]);
                    hold_idx = o_idx[sel];
                end
            end
            @(posedge clk); #1;
            t++;
        end
        out_ready = 1'b1;
        check_val("bins_seen", got, np, 0);
        check_val("in_ready_after", longint'(in_ready[sel]), 1, 0);
        check_val("valid_after", longint'(out_valid[sel]), 0, 0);
        check_val("busy_after", longint'(busy[sel]), 0, 0);
    endtask

    task automatic clear_samples();
        for (int n = 0; n < 32; n++) begin
            smp_r[n] = 0;
            smp_i[n] = 0;
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = '0; out_ready = 1'b0; inverse = 1'b0; in_r = '0; in_i = '0;
        #12;
        for (int g = 0; g < 3; g++) begin
            check_val("rst_in_ready", longint'(in_ready[g]), 1, 0);
            check_val("rst_out_valid", longint'(out_valid[g]), 0, 0);
            check_val("rst_busy", longint'(busy[g]), 0, 0);
            check_val("rst_out_last", longint'(out_last[g]), 0, 0);
            check_val("rst_out_r", o_r[g], 0, 0);
            check_val("rst_out_idx", o_idx[g], 0, 0);
        end
        rst = 1'b1;
        @(posedge clk); #1;

        // Impulse, N=8, with out_ready pattern 1,0,0,1
        clear_samples();
        smp_r[0] = 32'h0001_0000;
        push_dft(8, 1'b0, 0);
        send_frame(0, 8, 1'b0, 1'b0);
        collect(0, 8, 4'b1001, 20);

        // DC, N=8
        for (int n = 0; n < 8; n++) smp_r[n] = 32'h0001_0000;
        push_dft(8, 1'b0, 1);
        send_frame(0, 8, 1'b0, 1'b0);
        collect(0, 8, 4'b1111, 20);

        // Alternating +1/-1, N=16, with input gaps
        clear_samples();
        for (int n = 0; n < 16; n++) smp_r[n] = (n % 2 == 0) ? 65536 : -65536;
        push_dft(16, 1'b0, 2);
        send_frame(1, 16, 1'b0, 1'b1);
        collect(1, 16, 4'b1111, 0);

        // Round trip, N=32: forward random frame, then inverse of the captured bins
        for (int n = 0; n < 32; n++) begin
            smp_r[n] = int'($urandom_range(0, 16383)) - 8192;
            smp_i[n] = int'($urandom_range(0, 16383)) - 8192;
            org_r[n] = smp_r[n];
            org_i[n] = smp_i[n];
        end
        push_dft(32, 1'b0, 32);
        send_frame(2, 32, 1'b0, 1'b0);
        collect(2, 32, 4'b1111, 112);
        for (int n = 0; n < 32; n++) begin
            smp_r[n] = cap_r[n];
            smp_i[n] = cap_i[n];
            sb.push_back('{n, org_r[n], org_i[n], 4});
        end
        send_frame(2, 32, 1'b1, 1'b0);
        collect(2, 32, 4'b1001, 112);

        // Reset asserted during CALC discards the frame
        for (int n = 0; n < 8; n++) smp_r[n] = int'($urandom_range(0, 65535));
        send_frame(0, 8, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        check_val("busy_calc", longint'(busy[0]), 1, 0);
        check_val("in_ready_calc", longint'(in_ready[0]), 0, 0);
        check_val("out_r_idle", o_r[0], 0, 0);
        rst = 1'b0;
        #1;
        check_val("arst_out_valid", longint'(out_valid[0]), 0, 0);
        check_val("arst_in_ready", longint'(in_ready[0]), 1, 0);
        check_val("arst_busy", longint'(busy[0]), 0, 0);
        #20;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        clear_samples();
        smp_r[0] = 32'h0001_0000;
        push_dft(8, 1'b0, 0);
        send_frame(0, 8, 1'b0, 1'b0);
        collect(0, 8, 4'b0110, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
